rx_frame_checker: RTL and testbench
===================================

# rx_frame_checker

Receive-side frame integrity checker. It sits directly downstream of the Rx chain and consumes its recovered byte stream (`data_tdata`/`data_tvalid`/`data_tlast`/`data_tuser`). For each frame it checks length, payload bits against the known test pattern, and sequence continuity. It maintains saturating BER/frame statistics and a lock flag for ILA and GPIO monitoring.

## Interface
Parameters:
- `FRAME_LEN`, 32: bytes per frame, including the leading sequence byte; legal range 2..255.
- `LOCK_FRAMES`, 4: consecutive good frames required to assert `locked`.
- `UNLOCK_FRAMES`, 2: consecutive bad frames required to deassert `locked`.

Ports:
- `clk_2M048`  in  1: sole clock; all logic is on its rising edge.
- `rst_n_2M048`  in  1: synchronous, active-low reset.
- `clear`  in  1: synchronous pulse; zeroes all statistics counters.
- `data_tdata`  in  8: received byte.
- `data_tvalid`  in  1: byte valid. There is no tready; every valid byte must be accepted.
- `data_tlast`  in  1: last byte of frame.
- `data_tuser`  in  1: first byte of frame (the sequence byte).
- `frame_done`  out  1: one-cycle pulse when a frame closes.
- `frame_ok`  out  1: qualifies `frame_done`; 1 means the frame was good.
- `locked`  out  1: link-lock flag.
- `frame_cnt`  out  16: count of closed frames.
- `bad_frame_cnt`  out  16: count of bad frames.
- `lost_frame_cnt`  out  16: count of frames missing from the sequence.
- `bit_err_cnt`  out  32: count of payload bit errors.
- `bits_checked_cnt`  out  32: count of payload bits compared.

## Operation
- **Frame format:** byte 0 is `seq` (marked by `tuser`). Payload byte k (k = 1..FRAME_LEN-1) must equal `(seq + k) mod 256`.
- **Byte acceptance:** a byte is consumed only in cycles with `data_tvalid`=1. Gaps of `tvalid`=0 are ignored in any state.
- **FSM states:**
  - IDLE:
    - `tvalid & tuser`: capture `seq`, set `idx`=1, go to PAYLOAD.
    - `tvalid` without `tuser`: discard the byte and stay in IDLE.
    - If the capturing byte also has `tlast`, close the frame immediately as a length error (bad), unless FRAME_LEN=1 (illegal).
  - PAYLOAD, on each valid byte without `tuser`:
    - Compare the byte against `(seq+idx)`.
    - Add `popcount(tdata ^ expected)` to the per-frame error accumulator.
    - Add 8 to `bits_checked_cnt`.
    - Increment `idx`.
    - Close when `tlast`=1: good iff `idx`+1 == FRAME_LEN and the per-frame error count is 0.
    - If `idx`+1 == FRAME_LEN and `tlast`=0 (overlength): close as bad and go to DISCARD.
  - PAYLOAD, valid byte with `tuser`:
    - Close the current frame as bad (truncated).
    - In the same cycle, start a new frame with this byte as `seq` (stay in PAYLOAD, `idx`=1).
  - DISCARD: drop bytes until `tuser` (handled as in IDLE) or `tlast` (then go to IDLE).
- **Sequence check:** applies at each frame start, once a previous `seq` exists.
  - `lost_frame_cnt` += `(seq - prev_seq - 1) mod 256`.
  - `prev_seq` updates at every frame start, including for bad frames.
  - The first frame after reset or `clear` performs no check.
- **Lock logic:**
  - The good-run counter increments on each good close and resets on a bad close. `locked` sets when the run reaches LOCK_FRAMES.
  - The bad-run counter increments on each bad close and resets on a good close. `locked` clears when the run reaches UNLOCK_FRAMES.
- **Counters:** all saturate at all-ones. Bits from the sequence byte are never counted.
- **`clear`:**
  - Zeroes the five counters and forgets `prev_seq`.
  - Does not disturb the FSM, the per-frame accumulator, `locked`, or the run counters.
  - If `clear` coincides with an increment, `clear` wins: the result is 0.

## Timing
- **Reset:** all outputs 0, FSM in IDLE, `prev_seq` invalid, run counters 0. A reset mid-frame abandons the frame with no `frame_done`.
- **Latency:** `frame_done`, `frame_ok`, the counter updates and the `locked` change are all registered. They become visible in the cycle after the closing byte is accepted, and the last byte's bit errors are included.
- **Counter updates:** `bit_err_cnt` and `bits_checked_cnt` update one cycle after each accepted payload byte.
- **Per-frame accumulator:** 8 bits wide, saturating at 255. It is used only to decide good/bad.
- **Back-to-back bytes:** every cycle may carry a valid byte; throughput is one byte per clock with no bubbles required.
- **`frame_ok`:** 0 whenever `frame_done` is 0.

## Test plan
- **Clean run:** 3 frames with `seq` 0x10, 0x11, 0x12, FRAME_LEN=32, correct payload -> 3 `frame_done` pulses with `frame_ok`=1; `frame_cnt`=3, `bit_err_cnt`=0, `bits_checked_cnt`=744, `lost_frame_cnt`=0, `locked`=0. A 4th good frame -> `locked`=1 in the cycle after its `tlast`.
- **Bit errors:** payload byte k=5 XOR 0x81 -> `bit_err_cnt`=2, `bad_frame_cnt`=1, `frame_ok`=0; after 2 consecutive bad frames from a locked state, `locked`=0.
- **Sequence:** `seq` 0x10 then 0x13 -> `lost_frame_cnt`=2. `seq` 0xFF then 0x00 -> no increment.
- **Length faults:**
  - `tuser` arriving at `idx`=10 -> bad close, and the new frame is checked normally.
  - 40 bytes with no `tlast` -> bad close at byte 32, and the remaining 8 bytes are discarded without affecting `bits_checked_cnt`.
- **Flow gaps:** random `tvalid`=0 cycles inserted into clean frames -> results identical to the clean run.
- **Clear and reset:**
  - `clear` in the same cycle as `frame_done` -> all counters 0 next cycle, `locked` unchanged.
  - `rst_n_2M048`=0 mid-frame -> no `frame_done`, all outputs 0; the next frame is checked with no sequence comparison.

Source files
------------

// File: rtl/rx_frame_checker.sv
// rx_frame_checker: receive-side frame integrity checker.
// Checks length, payload pattern and sequence; keeps BER/lock stats.
module rx_frame_checker #(
  parameter int FRAME_LEN     = 32,
  parameter int LOCK_FRAMES   = 4,
  parameter int UNLOCK_FRAMES = 2
) (
  input  logic        clk_2M048,
  input  logic        rst_n_2M048,
  input  logic        clear,
  input  logic [7:0]  data_tdata,
  input  logic        data_tvalid,
  input  logic        data_tlast,
  input  logic        data_tuser,
  output logic        frame_done,
  output logic        frame_ok,
  output logic        locked,
  output logic [15:0] frame_cnt,
  output logic [15:0] bad_frame_cnt,
  output logic [15:0] lost_frame_cnt,
  output logic [31:0] bit_err_cnt,
  output logic [31:0] bits_checked_cnt
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PAYLOAD = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [7:0] seq_q;
  logic [7:0] idx_q;
  logic [7:0] acc_q;
  logic [7:0] prev_seq_q;
  logic       prev_vld_q;
  logic [7:0] good_run_q;
  logic [7:0] bad_run_q;

  logic       start;
  logic       pay;
  logic       trunc;
  logic       len_err;
  logic       at_end;
  logic       pay_close;
  logic       close_good;
  logic       any_close;
  logic [1:0] n_close;
  logic [7:0] expect_b;
  logic [7:0] diff;
  logic [3:0] pc;
  logic [8:0] acc_sum;
  logic [7:0] lost_inc;
  logic [8:0] good_nx;
  logic [8:0] bad_nx;

  function automatic logic [15:0] sat16(
    input logic [15:0] a,
    input logic [15:0] b
  );
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  function automatic logic [31:0] sat32(
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  // Byte classification and frame-close decode for this cycle.
  always_comb begin
    start      = data_tvalid & data_tuser;
    pay        = data_tvalid & ~data_tuser
               & (state_q == S_PAYLOAD);
    expect_b   = seq_q + idx_q;
    diff       = data_tdata ^ expect_b;
    pc         = 4'($countones(diff));
    acc_sum    = {1'b0, acc_q} + {5'd0, pc};
    at_end     = ({1'b0, idx_q} + 9'd1)
               == 9'(FRAME_LEN);
    trunc      = start & (state_q == S_PAYLOAD);
    len_err    = start & data_tlast;
    pay_close  = pay & (data_tlast | at_end);
    close_good = pay & data_tlast & at_end
               & (acc_q == 8'd0) & (pc == 4'd0);
    n_close    = {1'b0, trunc} + {1'b0, len_err}
               + {1'b0, pay_close};
    any_close  = n_close != 2'd0;
    lost_inc   = data_tdata - prev_seq_q - 8'd1;
    good_nx    = {1'b0, good_run_q} + 9'd1;
    bad_nx     = {1'b0, bad_run_q} + {7'd0, n_close};
  end

  // Next-state selection; gap cycles leave the state alone.
  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      start:
        state_d = data_tlast ? S_IDLE : S_PAYLOAD;
      pay:
        state_d = data_tlast ? S_IDLE :
                  (at_end ? S_DISCARD : S_PAYLOAD);
      (state_q == S_DISCARD) & data_tvalid
        & ~data_tuser & data_tlast:
        state_d = S_IDLE;
      default: ;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_2M048) begin
    if (!rst_n_2M048) state_q <= S_IDLE;
    else              state_q <= state_d;
  end

  // Per-frame context: sequence byte, index, error accumulator.
  always_ff @(posedge clk_2M048) begin
    if (!rst_n_2M048) begin
      seq_q <= 8'd0;
      idx_q <= 8'd0;
      acc_q <= 8'd0;
    end else if (start) begin
      seq_q <= data_tdata;
      idx_q <= 8'd1;
      acc_q <= 8'd0;
    end else if (pay) begin
      idx_q <= idx_q + 8'd1;
      acc_q <= acc_sum[8] ? 8'hFF : acc_sum[7:0];
    end
  end

  // Statistics counters and sequence tracking; clear beats increments.
  always_ff @(posedge clk_2M048) begin
    if (!rst_n_2M048 || clear) begin
      frame_cnt        <= 16'd0;
      bad_frame_cnt    <= 16'd0;
      lost_frame_cnt   <= 16'd0;
      bit_err_cnt      <= 32'd0;
      bits_checked_cnt <= 32'd0;
      prev_seq_q       <= 8'd0;
      prev_vld_q       <= 1'b0;
    end else begin
      frame_cnt <= sat16(frame_cnt, {14'd0, n_close});
      bad_frame_cnt <= sat16(bad_frame_cnt,
        close_good ? 16'd0 : {14'd0, n_close});
      if (start) begin
        prev_seq_q <= data_tdata;
        prev_vld_q <= 1'b1;
        if (prev_vld_q)
          lost_frame_cnt <= sat16(lost_frame_cnt,
                                  {8'd0, lost_inc});
      end
      if (pay) begin
        bit_err_cnt <= sat32(bit_err_cnt, {28'd0, pc});
        bits_checked_cnt <= sat32(bits_checked_cnt, 32'd8);
      end
    end
  end

  // Close pulse, run counters and lock flag.
  always_ff @(posedge clk_2M048) begin
    if (!rst_n_2M048) begin
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      locked     <= 1'b0;
      good_run_q <= 8'd0;
      bad_run_q  <= 8'd0;
    end else begin
      frame_done <= any_close;
      frame_ok   <= close_good;
      if (close_good) begin
        good_run_q <= good_nx[8] ? 8'hFF : good_nx[7:0];
        bad_run_q  <= 8'd0;
        if (good_nx >= 9'(LOCK_FRAMES)) locked <= 1'b1;
      end else if (any_close) begin
        bad_run_q  <= bad_nx[8] ? 8'hFF : bad_nx[7:0];
        good_run_q <= 8'd0;
        if (bad_nx >= 9'(UNLOCK_FRAMES)) locked <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rx_frame_checker.sv
// tb_rx_frame_checker: randomized bench for rx_frame_checker.
// Frame-level reference model, compared every cycle.
module tb_rx_frame_checker;
  localparam int FL      = 32;
  localparam int LOCKN   = 4;
  localparam int UNLOCKN = 2;

  logic        clk_2M048 = 1'b0;
  logic        rst_n_2M048;
  logic        clear;
  logic [7:0]  data_tdata;
  logic        data_tvalid;
  logic        data_tlast;
  logic        data_tuser;
  logic        frame_done;
  logic        frame_ok;
  logic        locked;
  logic [15:0] frame_cnt;
  logic [15:0] bad_frame_cnt;
  logic [15:0] lost_frame_cnt;
  logic [31:0] bit_err_cnt;
  logic [31:0] bits_checked_cnt;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  longint m_frames, m_bad, m_lost, m_err, m_bits;
  bit     m_done, m_ok, m_locked;
  int     good_run, bad_run;
  bit     prev_valid;
  logic [7:0] prev_seq;
  bit     frame_open;

  longint e_frames, e_bad, e_lost, e_err, e_bits;
  bit     e_done, e_ok, e_locked;

  logic [7:0] emask [0:63];

  rx_frame_checker #(
    .FRAME_LEN(FL),
    .LOCK_FRAMES(LOCKN),
    .UNLOCK_FRAMES(UNLOCKN)
  ) dut (
    .clk_2M048(clk_2M048),
    .rst_n_2M048(rst_n_2M048),
    .clear(clear),
    .data_tdata(data_tdata),
    .data_tvalid(data_tvalid),
    .data_tlast(data_tlast),
    .data_tuser(data_tuser),
    .frame_done(frame_done),
    .frame_ok(frame_ok),
    .locked(locked),
    .frame_cnt(frame_cnt),
    .bad_frame_cnt(bad_frame_cnt),
    .lost_frame_cnt(lost_frame_cnt),
    .bit_err_cnt(bit_err_cnt),
    .bits_checked_cnt(bits_checked_cnt)
  );

  always #5 clk_2M048 = ~clk_2M048;

  task automatic cmp(input string name, input longint act,
                     input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic longint satc(input longint v,
                                  input longint mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic void snap();
    e_frames = m_frames; e_bad = m_bad; e_lost = m_lost;
    e_err = m_err; e_bits = m_bits;
    e_done = m_done; e_ok = m_ok; e_locked = m_locked;
  endfunction

  function automatic void clr_mask();
    foreach (emask[i]) emask[i] = 8'd0;
  endfunction

  // Per-cycle comparison of every output against the model.
  always @(negedge clk_2M048) begin
    if (chk_en) begin
      cmp("frame_done", longint'(frame_done), longint'(e_done));
      cmp("frame_ok", longint'(frame_ok), longint'(e_ok));
      cmp("locked", longint'(locked), longint'(e_locked));
      cmp("frame_cnt", longint'(frame_cnt), e_frames);
      cmp("bad_frame_cnt", longint'(bad_frame_cnt), e_bad);
      cmp("lost_frame_cnt", longint'(lost_frame_cnt), e_lost);
      cmp("bit_err_cnt", longint'(bit_err_cnt), e_err);
      cmp("bits_checked_cnt", longint'(bits_checked_cnt), e_bits);
    end
  end

  task automatic tick(input bit v, input logic [7:0] d,
                      input bit last, input bit user,
                      input bit clr, input int nc,
                      input bit good, input int lost,
                      input int ei, input int bi);
    data_tvalid = v; data_tdata = d;
    data_tlast = last; data_tuser = user; clear = clr;
    m_done = (nc > 0);
    m_ok = good;
    if (nc > 0) begin
      if (good) begin
        good_run++; bad_run = 0;
        if (good_run >= LOCKN) m_locked = 1'b1;
      end else begin
        bad_run += nc; good_run = 0;
        if (bad_run >= UNLOCKN) m_locked = 1'b0;
      end
    end
    if (clr) begin
      m_frames = 0; m_bad = 0; m_lost = 0;
      m_err = 0; m_bits = 0; prev_valid = 1'b0;
    end else begin
      m_frames = satc(m_frames + nc, 65535);
      m_bad = satc(m_bad + (good ? 0 : nc), 65535);
      m_lost = satc(m_lost + lost, 65535);
      m_err = satc(m_err + ei, 64'hFFFF_FFFF);
      m_bits = satc(m_bits + bi, 64'hFFFF_FFFF);
    end
    @(posedge clk_2M048);
    snap();
    #1;
  endtask

  task automatic gap(input bit clr);
    tick(1'b0, 8'($urandom), bit'($urandom_range(1)),
         bit'($urandom_range(1)), clr, 0, 1'b0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst_n_2M048 = 1'b0; clear = 1'b0;
    data_tvalid = 1'b0; data_tdata = 8'd0;
    data_tlast = 1'b0; data_tuser = 1'b0;
    m_frames = 0; m_bad = 0; m_lost = 0; m_err = 0; m_bits = 0;
    m_done = 1'b0; m_ok = 1'b0; m_locked = 1'b0;
    good_run = 0; bad_run = 0;
    prev_valid = 1'b0; prev_seq = 8'd0; frame_open = 1'b0;
    repeat (2) begin
      @(posedge clk_2M048);
      snap();
      #1;
    end
    rst_n_2M048 = 1'b1;
  endtask

  // Sends seq plus nb-1 pattern bytes (emask corrupts byte j).
  task automatic send_frame(input logic [7:0] seq, input int nb,
                            input bit has_last, input int gap_pct,
                            input bit clr_last);
    int errs;
    errs = 0;
    for (int j = 0; j < nb; j++) begin
      logic [7:0] b;
      bit last, good;
      int nc, lost, ei, bi;
      while (gap_pct > 0 && $urandom_range(99) < gap_pct)
        gap(1'b0);
      last = has_last && (j == nb - 1);
      nc = 0; good = 1'b0; lost = 0; ei = 0; bi = 0;
      b = (seq + 8'(j)) ^ emask[j];
      if (j == 0) begin
        b = seq;
        if (frame_open) nc++;
        if (prev_valid)
          lost = int'(8'(seq - prev_seq - 8'd1));
        prev_seq = seq; prev_valid = 1'b1; frame_open = 1'b1;
        if (last) begin nc++; frame_open = 1'b0; end
      end else if (j < FL) begin
        ei = $countones(emask[j]); bi = 8; errs += ei;
        if (last || j == FL - 1) begin
          nc = 1;
          good = last && (j == FL - 1) && (errs == 0);
          frame_open = 1'b0;
        end
      end
      tick(1'b1, b, last, j == 0, clr_last && (j == nb - 1),
           nc, good, lost, ei, bi);
    end
  endtask

  initial begin
    logic [7:0] s;
    int kind, nb;
    bit hl;
    clr_mask();
    do_reset();
    chk_en = 1'b1;
    cmp("rst_frame_cnt", longint'(frame_cnt), 0);
    cmp("rst_locked", longint'(locked), 0);
    cmp("rst_bits", longint'(bits_checked_cnt), 0);
    cmp("rst_done", longint'(frame_done), 0);

    send_frame(8'h10, FL, 1'b1, 0, 1'b0);
    send_frame(8'h11, FL, 1'b1, 0, 1'b0);
    send_frame(8'h12, FL, 1'b1, 0, 1'b0);
    cmp("clean_frames", longint'(frame_cnt), 3);
    cmp("clean_bits", longint'(bits_checked_cnt), 744);
    cmp("clean_err", longint'(bit_err_cnt), 0);
    cmp("clean_lost", longint'(lost_frame_cnt), 0);
    cmp("clean_unlocked", longint'(locked), 0);
    send_frame(8'h13, FL, 1'b1, 0, 1'b0);
    cmp("lock_set", longint'(locked), 1);
    cmp("good_ok", longint'(frame_ok), 1);

    tick(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 0, 0, 0);
    cmp("clr_frames", longint'(frame_cnt), 0);
    cmp("clr_bits", longint'(bits_checked_cnt), 0);
    cmp("clr_keeps_lock", longint'(locked), 1);

    emask[5] = 8'h81;
    send_frame(8'h14, FL, 1'b1, 0, 1'b0);
    clr_mask();
    cmp("biterr_cnt", longint'(bit_err_cnt), 2);
    cmp("biterr_bad", longint'(bad_frame_cnt), 1);
    cmp("biterr_ok", longint'(frame_ok), 0);
    cmp("biterr_done", longint'(frame_done), 1);
    cmp("one_bad_locked", longint'(locked), 1);
    emask[3] = 8'h01;
    send_frame(8'h15, FL, 1'b1, 0, 1'b0);
    clr_mask();
    cmp("unlock", longint'(locked), 0);
    cmp("biterr_cnt2", longint'(bit_err_cnt), 3);

    tick(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 0, 0, 0);
    send_frame(8'h10, FL, 1'b1, 0, 1'b0);
    send_frame(8'h13, FL, 1'b1, 0, 1'b0);
    cmp("lost_gap2", longint'(lost_frame_cnt), 2);
    send_frame(8'hFF, FL, 1'b1, 0, 1'b0);
    send_frame(8'h00, FL, 1'b1, 0, 1'b0);
    cmp("lost_wrap", longint'(lost_frame_cnt), 237);

    send_frame(8'h01, 10, 1'b0, 0, 1'b0);
    send_frame(8'h02, FL, 1'b1, 0, 1'b0);
    cmp("trunc_bad", longint'(bad_frame_cnt), 1);
    cmp("trunc_frames", longint'(frame_cnt), 6);
    cmp("after_trunc_ok", longint'(frame_ok), 1);
    cmp("trunc_bits", longint'(bits_checked_cnt), 1312);

    send_frame(8'h03, 40, 1'b0, 0, 1'b0);
    cmp("over_bits", longint'(bits_checked_cnt), 1560);
    cmp("over_bad", longint'(bad_frame_cnt), 2);
    send_frame(8'h04, FL, 1'b1, 0, 1'b0);
    cmp("after_over_ok", longint'(frame_ok), 1);

    tick(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 0, 0, 0);
    send_frame(8'h10, FL, 1'b1, 30, 1'b0);
    send_frame(8'h11, FL, 1'b1, 30, 1'b0);
    send_frame(8'h12, FL, 1'b1, 30, 1'b0);
    cmp("gap_frames", longint'(frame_cnt), 3);
    cmp("gap_bits", longint'(bits_checked_cnt), 744);
    cmp("gap_err", longint'(bit_err_cnt), 0);

    send_frame(8'h13, FL, 1'b1, 0, 1'b1);
    cmp("clr_wins_frames", longint'(frame_cnt), 0);
    cmp("clr_wins_bits", longint'(bits_checked_cnt), 0);
    cmp("clr_wins_ok", longint'(frame_ok), 1);

    s = 8'h20;
    for (int f = 0; f < 300; f++) begin
      s = ($urandom_range(9) < 8) ? s + 8'd1 : 8'($urandom);
      clr_mask();
      if ($urandom_range(3) == 0) begin
        emask[$urandom_range(1, FL - 1)] = 8'($urandom);
        emask[$urandom_range(1, FL - 1)] = 8'($urandom);
      end
      kind = $urandom_range(99);
      nb = FL; hl = 1'b1;
      if (kind < 70) begin
        nb = FL;
      end else if (kind < 78) begin
        nb = $urandom_range(2, FL - 1);
      end else if (kind < 85) begin
        nb = $urandom_range(2, FL - 1); hl = 1'b0;
      end else if (kind < 92) begin
        nb = $urandom_range(FL + 1, 45);
        hl = bit'($urandom_range(1));
      end else if (!frame_open) begin
        nb = 1;
      end
      if (!frame_open && $urandom_range(9) == 0)
        repeat ($urandom_range(1, 3))
          tick(1'b1, 8'($urandom), bit'($urandom_range(1)),
               1'b0, 1'b0, 0, 1'b0, 0, 0, 0);
      if ($urandom_range(49) == 0) gap(1'b1);
      send_frame(s, nb, hl, ($urandom_range(1) == 1) ? 20 : 0,
                 $urandom_range(32) == 0);
    end
    clr_mask();

    send_frame(8'h40, FL, 1'b1, 0, 1'b0);
    tick(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 0, 0, 0);
    s = 8'h80;
    for (int f = 0; f < 270; f++) begin
      send_frame(s, 2, 1'b1, 0, 1'b0);
      s = s - 8'd1;
    end
    cmp("lost_sat", longint'(lost_frame_cnt), 65535);
    cmp("sat_frames", longint'(frame_cnt), 270);
    cmp("sat_unlocked", longint'(locked), 0);

    send_frame(8'h50, 10, 1'b0, 0, 1'b0);
    do_reset();
    cmp("mid_rst_done", longint'(frame_done), 0);
    cmp("mid_rst_frames", longint'(frame_cnt), 0);
    cmp("mid_rst_lost", longint'(lost_frame_cnt), 0);
    send_frame(8'h60, FL, 1'b1, 0, 1'b0);
    cmp("post_rst_lost", longint'(lost_frame_cnt), 0);
    cmp("post_rst_ok", longint'(frame_ok), 1);
    send_frame(8'h61, FL, 1'b1, 0, 1'b0);
    cmp("post_rst_frames", longint'(frame_cnt), 2);
    repeat (3) gap(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
